// File: rtl/conv_mac_accumulator.sv
// Reduces nine 3x3-window products per beat through a two-stage adder tree and
// accumulates beat sums over num_ch channels into one saturated result per pixel.
module conv_mac_accumulator #(
    parameter int W_PROD = 16,
    parameter int W_ACC  = 24,
    parameter int W_CH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_CH-1:0]       num_ch,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*W_PROD-1:0]   prod,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W_ACC-1:0]      out_data,
    output logic                  sat,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    localparam logic [W_CH-1:0]  ONE_CH  = W_CH'(1);
    localparam logic [W_ACC-1:0] ACC_MAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

    state_t            state, state_next;
    logic [W_CH-1:0]   num_q;
    logic [W_CH-1:0]   cnt;
    logic [W_ACC-1:0]  ext [9];
    logic [W_ACC-1:0]  s1 [3];
    logic              s1_valid;
    logic [W_ACC-1:0]  s2;
    logic              s2_valid;
    logic [W_ACC-1:0]  acc;
    logic [W_ACC:0]    acc_sum;
    logic [W_ACC-1:0]  acc_clamped;
    logic              acc_ovf;
    logic              accept;
    logic              last_beat;
    logic              drain_done;

    for (genvar i = 0; i < 9; i++) begin : g_ext
        assign ext[i] = {{(W_ACC-W_PROD){prod[i*W_PROD+W_PROD-1]}}, prod[i*W_PROD +: W_PROD]};
    end

    assign in_ready   = (state == ACCUM) && (cnt < num_q);
    assign accept     = in_valid && in_ready;
    assign last_beat  = accept && ((cnt + ONE_CH) == num_q);
    assign drain_done = !s1_valid && !s2_valid;
    assign busy       = (state != IDLE);
    assign out_valid  = (state == OUT);

    // One extra bit catches overflow; the two top bits disagreeing means out of range.
    assign acc_sum     = {acc[W_ACC-1], acc} + {s2[W_ACC-1], s2};
    assign acc_ovf     = acc_sum[W_ACC] ^ acc_sum[W_ACC-1];
    assign acc_clamped = acc_ovf ? (acc_sum[W_ACC] ? ACC_MIN : ACC_MAX) : acc_sum[W_ACC-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = ACCUM;
            ACCUM:   if (last_beat)  state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = OUT;
            OUT:     if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q    <= '0;
            cnt      <= '0;
            s1[0]    <= '0;
            s1[1]    <= '0;
            s1[2]    <= '0;
            s1_valid <= 1'b0;
            s2       <= '0;
            s2_valid <= 1'b0;
            acc      <= '0;
            sat      <= 1'b0;
            out_data <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1[0] <= ext[0] + ext[1] + ext[2];
                s1[1] <= ext[3] + ext[4] + ext[5];
                s1[2] <= ext[6] + ext[7] + ext[8];
            end
            s2_valid <= s1_valid;
            if (s1_valid) s2 <= s1[0] + s1[1] + s1[2];

            if (state == IDLE && start) begin
                num_q <= (num_ch == '0) ? ONE_CH : num_ch;
                cnt   <= '0;
                acc   <= '0;
                sat   <= 1'b0;
            end else begin
                if (accept) cnt <= cnt + ONE_CH;
                if (s2_valid) begin
                    acc <= acc_clamped;
                    if (acc_ovf) sat <= 1'b1;
                end
            end

            if (state == DRAIN && drain_done) out_data <= acc;
        end
    end

endmodule

// File: tb/tb_conv_mac_accumulator.sv
// Randomized bench for conv_mac_accumulator: a driver issues pixels and pushes model
// results into a queue; a monitor pops and compares on every output transfer.
module tb_conv_mac_accumulator;

    localparam int W_PROD = 16;
    localparam int W_ACC  = 24;
    localparam int W_CH   = 8;

    localparam int K_RAND  = 0;
    localparam int K_SEQ   = 1;
    localparam int K_TWO   = 2;
    localparam int K_NEG1  = 3;
    localparam int K_MAX   = 4;
    localparam int K_MIN   = 5;
    localparam int K_SMALL = 6;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [W_CH-1:0]      num_ch;
    logic                 in_valid;
    logic                 in_ready;
    logic [9*W_PROD-1:0]  prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [W_ACC-1:0]     out_data;
    logic                 sat;
    logic                 busy;

    logic [W_ACC:0]       exp_q[$];
    int                   n_cmp;
    int                   n_fail;
    bit                   ready_rand;
    bit                   ready_force;

    conv_mac_accumulator #(.W_PROD(W_PROD), .W_ACC(W_ACC), .W_CH(W_CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ch    (num_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat       (sat),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // out_ready is driven only here, either randomly or from ready_force
    always @(posedge clk) begin
        #2;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W_ACC:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h expected no result", {sat, out_data});
            end else begin
                e = exp_q.pop_front();
                if ({sat, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL result: got sat=%0d data=0x%0h expected sat=%0d data=0x%0h",
                             sat, out_data, e[W_ACC], e[W_ACC-1:0]);
                end
            end
        end
    end

    function automatic logic [15:0] gen_prod(input int kind, input int i);
        case (kind)
            K_SEQ:   return 16'(i + 1);
            K_TWO:   return 16'd2;
            K_NEG1:  return 16'hFFFF;
            K_MAX:   return 16'h7FFF;
            K_MIN:   return 16'h8000;
            K_SMALL: return 16'($urandom_range(0, 20)) - 16'd10;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: got busy=1 expected busy=0 within 3000 cycles");
        end
    endtask

    // driver: one pixel, reference model computed from the sum/clamp rules
    task automatic run_pixel(input int n, input int kind, input bit chk_lat);
        int     eff, got, guard, lat, beat;
        longint acc_m, maxv, minv;
        bit     sat_m;
        logic [W_ACC-1:0] acc_bits;
        maxv  = (longint'(1) << (W_ACC - 1)) - 1;
        minv  = -(longint'(1) << (W_ACC - 1));
        eff   = (n == 0) ? 1 : n;
        acc_m = 0;
        sat_m = 0;
        wait_idle();
        @(posedge clk); #1;
        start  = 1'b1;
        num_ch = W_CH'(n);
        @(posedge clk); #1;
        start = 1'b0;
        got   = 0;
        guard = 0;
        while (got < eff && guard < 20000) begin
            in_valid = (kind == K_TWO) ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 9; i++)
                prod[i*W_PROD +: W_PROD] = in_valid ? gen_prod(kind, i) : 16'($urandom_range(0, 65535));
            @(negedge clk);
            if (in_valid && in_ready) begin
                beat = 0;
                for (int i = 0; i < 9; i++) beat += int'($signed(prod[i*W_PROD +: W_PROD]));
                acc_m = acc_m + beat;
                if (acc_m > maxv) begin acc_m = maxv; sat_m = 1; end
                if (acc_m < minv) begin acc_m = minv; sat_m = 1; end
                got++;
            end
            guard++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (got < eff) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_accept: got %0d beats expected %0d", got, eff);
            return;
        end
        acc_bits = acc_m[W_ACC-1:0];
        exp_q.push_back({sat_m, acc_bits});
        @(negedge clk);
        check("in_ready_after_last", 32'(in_ready), 32'd0);
        if (chk_lat) begin
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("out_valid_latency_edges", 32'(lat), 32'd4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_sat"},       32'(sat),       32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        logic [W_ACC:0] hold_exp;
        int guard;
        bit seen;
        n_cmp       = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        num_ch      = '0;
        in_valid    = 1'b0;
        prod        = '0;
        out_ready   = 1'b0;
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // directed pixels
        run_pixel(1,   K_SEQ,  1);   // 45
        run_pixel(3,   K_TWO,  0);   // 54, toggling in_valid
        run_pixel(0,   K_NEG1, 0);   // -9
        run_pixel(200, K_MAX,  0);   // +max, sat
        run_pixel(2,   K_SMALL,0);   // sat cleared
        run_pixel(200, K_MIN,  0);   // -min, sat

        // random pixels with random backpressure
        ready_rand = 1'b1;
        for (int p = 0; p < 20; p++)
            run_pixel($urandom_range(0, 6), ($urandom_range(0, 1) != 0) ? K_RAND : K_SMALL, 0);

        // output held under backpressure; start ignored while in OUT
        ready_rand  = 1'b0;
        ready_force = 1'b1;
        wait_idle();
        ready_force = 1'b0;
        run_pixel(2, K_SMALL, 0);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold_exp = exp_q[0];
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start  = (k % 2 == 1);
            num_ch = 8'd5;
            @(negedge clk);
            check("bp_hold_data",     32'(out_data),  32'(hold_exp[W_ACC-1:0]));
            check("bp_hold_in_ready", 32'(in_ready),  32'd0);
            check("bp_hold_valid",    32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        start       = 1'b1;
        ready_force = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bp_release_busy",      32'(busy),      32'd0);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_start_ignored_busy", 32'(busy), 32'd0);

        // reset in the middle of a 4-channel pixel
        wait_idle();
        @(posedge clk); #1;
        start  = 1'b1;
        num_ch = 8'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) prod[i*W_PROD +: W_PROD] = 16'(i + 1);
        @(negedge clk);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midreset_no_output", 32'(seen), 32'd0);
        run_pixel(1, K_SEQ, 0);      // 45

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
